// File: rtl/rr_priority_arbiter_if.sv
// Request/grant bundle for rr_priority_arbiter.
// The slave side is the arbiter. The master side is the request source plus the grant consumer.
interface rr_priority_arbiter_if #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) ();
    logic [N-1:0] req;
    logic         rr_en;
    logic         out_ready;
    logic         out_valid;
    logic [W-1:0] out_idx;
    logic [N-1:0] out_onehot;

    modport master (
        output req, rr_en, out_ready,
        input  out_valid, out_idx, out_onehot
    );

    modport slave (
        input  req, rr_en, out_ready,
        output out_valid, out_idx, out_onehot
    );
endinterface

// File: rtl/rr_priority_arbiter.sv
// Registered N-way arbiter with a valid/ready handshake on its output.
// It supports fixed priority (highest index wins) and round-robin selection.
module rr_priority_arbiter #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input logic                  clk,
    input logic                  rst_n,
    rr_priority_arbiter_if.slave bus
);
    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    logic [W-1:0] ptr;
    logic [W-1:0] next_ptr;
    logic [W-1:0] ptr_eff;
    logic [W-1:0] fx_win;
    logic [W-1:0] rr_win;
    logic [W-1:0] winner;
    logic [W-1:0] cand;
    logic         rr_found;
    logic         accept;
    logic         load;
    logic         any_req;

    function automatic int wrap_dn(int p, int o);
        return (p - o + N) % N;
    endfunction

    assign accept   = bus.out_valid && bus.out_ready;
    assign load     = !bus.out_valid || bus.out_ready;
    assign any_req  = |bus.req;
    assign next_ptr = (bus.out_idx == '0) ? W'(N - 1) : bus.out_idx - W'(1);
    // A grant that is accepted this cycle moves the search start for the winner loaded in the same cycle.
    assign ptr_eff  = accept ? next_ptr : ptr;

    always_comb begin
        fx_win = '0;
        for (int i = 0; i < N; i++) begin
            if (bus.req[i]) fx_win = W'(i);
        end
    end

    always_comb begin
        rr_win   = '0;
        rr_found = 1'b0;
        cand     = '0;
        for (int o = 0; o < N; o++) begin
            cand = W'(wrap_dn(int'(ptr_eff), o));
            if (!rr_found && bus.req[cand]) begin
                rr_found = 1'b1;
                rr_win   = cand;
            end
        end
    end

    assign winner = bus.rr_en ? rr_win : fx_win;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.out_valid  <= 1'b0;
            bus.out_idx    <= '0;
            bus.out_onehot <= '0;
            ptr            <= W'(N - 1);
        end else begin
            ptr <= ptr_eff;
            if (load) begin
                bus.out_valid  <= any_req;
                bus.out_idx    <= any_req ? winner : '0;
                bus.out_onehot <= any_req ? (ONE << winner) : '0;
            end
        end
    end
endmodule

// File: tb/tb_rr_priority_arbiter.sv
// Self-checking bench for rr_priority_arbiter with N=8.
// It runs directed scenario vectors first, then random traffic checked against a reference model.
module tb_rr_priority_arbiter;
    localparam int N = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rr_priority_arbiter_if #(.N(N)) bus ();
    rr_priority_arbiter #(.N(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic       rst_n;
        logic [7:0] req;
        logic       rr_en;
        logic       rdy;
        logic       exp_valid;
        int         exp_idx;
    } vec_t;
    vec_t vecs[$];

    // Reference state: the presented grant and the round-robin start point.
    bit m_valid = 1'b0;
    int m_idx = 0;
    int m_ptr = N - 1;

    function automatic void add(logic r, logic [7:0] rq, logic rr, logic rd, logic ev, int ei);
        vec_t v;
        v.rst_n = r; v.req = rq; v.rr_en = rr; v.rdy = rd; v.exp_valid = ev; v.exp_idx = ei;
        vecs.push_back(v);
    endfunction

    // Build the search list in order, then take the first requester in it.
    function automatic int pick(logic [7:0] rq, bit rr, int p);
        int order[$];
        for (int k = 0; k < N; k++)
            order.push_back(rr ? (p - k + N) % N : N - 1 - k);
        foreach (order[k])
            if (rq[order[k]]) return order[k];
        return 0;
    endfunction

    function automatic void model_step(logic r, logic [7:0] rq, logic rr, logic rd);
        bit was_free;
        if (!r) begin
            m_valid = 1'b0; m_idx = 0; m_ptr = N - 1;
            return;
        end
        was_free = !m_valid || rd;
        if (m_valid && rd) m_ptr = (m_idx == 0) ? N - 1 : m_idx - 1;
        if (was_free) begin
            if (rq != 0) begin m_valid = 1'b1; m_idx = pick(rq, rr, m_ptr); end
            else begin m_valid = 1'b0; m_idx = 0; end
        end
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step(logic r, logic [7:0] rq, logic rr, logic rd);
        rst_n = r; bus.req = rq; bus.rr_en = rr; bus.out_ready = rd;
        @(posedge clk);
        model_step(r, rq, rr, rd);
        @(negedge clk);
    endtask

    initial begin
        bus.req = '0; bus.rr_en = 1'b0; bus.out_ready = 1'b0;

        // Reset is held with requests present, then the round-robin sweep over all-ones runs.
        repeat (3) add(0, 8'hFF, 1, 1, 0, 0);
        add(1, 8'hFF, 1, 1, 1, 7);
        for (int k = 6; k >= 0; k--) add(1, 8'hFF, 1, 1, 1, k);
        add(1, 8'hFF, 1, 1, 1, 7);
        // Fixed priority on a held request vector, then the vector goes empty.
        repeat (3) add(1, 8'b0010_0100, 0, 1, 1, 5);
        repeat (2) add(1, 8'h00, 0, 1, 0, 0);
        // Sparse round-robin, then a switch to fixed mode.
        add(0, 8'h00, 1, 1, 0, 0);
        add(1, 8'h81, 1, 1, 1, 7);
        add(1, 8'h81, 1, 1, 1, 0);
        add(1, 8'h81, 1, 1, 1, 7);
        add(1, 8'h81, 1, 1, 1, 0);
        repeat (2) add(1, 8'h81, 0, 1, 1, 7);
        // The grant holds under back-pressure even after the granted bit drops.
        add(0, 8'h00, 0, 0, 0, 0);
        add(1, 8'h08, 0, 0, 1, 3);
        repeat (4) add(1, 8'h80, 0, 0, 1, 3);
        add(1, 8'h80, 0, 1, 1, 7);
        add(1, 8'h80, 0, 0, 1, 7);
        // Reset during a hold drops the grant and restores the pointer.
        add(0, 8'h00, 1, 0, 0, 0);
        add(1, 8'h10, 1, 0, 1, 4);
        add(1, 8'hFF, 1, 0, 1, 4);
        add(0, 8'hFF, 1, 0, 0, 0);
        add(1, 8'hFF, 1, 0, 1, 7);

        @(negedge clk);
        foreach (vecs[k]) begin
            step(vecs[k].rst_n, vecs[k].req, vecs[k].rr_en, vecs[k].rdy);
            check($sformatf("vec%0d_valid", k), 32'(bus.out_valid), 32'(vecs[k].exp_valid));
            check($sformatf("vec%0d_idx", k), 32'(bus.out_idx),
                  vecs[k].exp_valid ? vecs[k].exp_idx : 0);
            check($sformatf("vec%0d_onehot", k), 32'(bus.out_onehot),
                  vecs[k].exp_valid ? (32'd1 << vecs[k].exp_idx) : 32'd0);
        end

        // Random traffic, checked cycle by cycle against the reference model.
        for (int c = 0; c < 600; c++) begin
            logic [7:0] rq;
            int sel;
            sel = int'($urandom_range(0, 9));
            rq = (sel == 0) ? 8'h00 : (sel == 1) ? 8'hFF : 8'($urandom);
            step(($urandom_range(0, 59) != 0), rq, 1'($urandom), ($urandom_range(0, 9) < 7));
            check($sformatf("rnd%0d_valid", c), 32'(bus.out_valid), 32'(m_valid));
            check($sformatf("rnd%0d_idx", c), 32'(bus.out_idx), m_idx);
            check($sformatf("rnd%0d_onehot", c), 32'(bus.out_onehot),
                  m_valid ? (32'd1 << m_idx) : 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rr_priority_arbiter.md
# rr_priority_arbiter

Parametrised, registered priority arbiter with a valid/ready output handshake. It takes N request lines and selects a single winner. Two selection modes are available: fixed priority, where the highest index wins, or round-robin. The winner is presented as a binary index plus a one-hot grant, and is held stable until the consumer accepts it. It sits between request sources and a shared resource, and replaces single-cycle combinational encoders wherever fairness or back-pressure is needed.

## Interface
- N, default 8: number of request lines; legal values are 2 or more.
- W, default $clog2(N): width of the index output. Derived; do not override.

- clk  input  1  Clock; all state updates on the rising edge.
- rst_n  input  1  Reset, synchronous, active-low.
- req  input  N  Request vector; bit i set means requester i is pending. Level-sensitive.
- rr_en  input  1  Mode select: 1 = round-robin, 0 = fixed priority.
- out_ready  input  1  Consumer accepts the current grant this cycle.
- out_valid  output  1  A grant is being presented.
- out_idx  output  W  Index of the granted requester.
- out_onehot  output  N  One-hot form of out_idx; all zero when out_valid=0.

## Operation
**Slot free condition**
- load = !out_valid || out_ready.
- req and rr_en are only sampled on a load cycle. At all other times they are ignored.

**On a load cycle**
- If req != 0: out_valid <= 1, out_idx <= winner, out_onehot <= 1 << winner.
- If req == 0: out_valid <= 0, out_idx <= 0, out_onehot <= 0.

**Fixed mode (rr_en=0)**
- The winner is the highest set index of req. Bit N-1 has top priority.

**Round-robin mode (rr_en=1)**
- A pointer ptr (W bits) sets the search order: ptr, ptr-1, …, 0, N-1, …, ptr+1, with wrap modulo N.
- The winner is the first set bit found in that order.

**Pointer update**
- On acceptance (out_valid && out_ready) of index k, ptr <= (k==0) ? N-1 : k-1. This happens regardless of mode.
- Fixed mode ignores ptr. Switching to round-robin therefore resumes from the last accepted grant.

**Holding under back-pressure**
- While out_valid=1 and out_ready=0, out_idx and out_onehot hold.
- Changes on req during this time do not retract or alter the grant, including deassertion of the granted bit.

**Mode change**
- A change on rr_en takes effect at the next load cycle only.

**Width rules**
- If N is not a power of two, out_idx never exceeds N-1.
- Pointer wrap goes from 0 to N-1, never to 2^W-1.

## Timing
**Reset**
- Reset values, applied on the clock edge with rst_n=0: out_valid=0, out_idx=0, out_onehot=0, ptr=N-1.
- Reset overrides any load or acceptance in the same cycle.
- Reset applied mid-hold drops the pending grant. The grant is not counted as accepted and ptr returns to N-1.

**Latency and throughput**
- Latency: req sampled on load cycle t gives out_valid/out_idx valid at cycle t+1.
- Throughput: with out_ready held at 1 and req nonzero, one grant is issued every cycle with no bubble.
- Simultaneous accept and new request: the accepting cycle is also a load cycle. The next winner uses the already-updated ptr value, i.e. the post-acceptance pointer.
- The first grant after reset in round-robin mode equals the fixed-priority result, because ptr=N-1.

**Empty and full cases**
- All requests clear on a load cycle: out_valid deasserts the next cycle.
- All requests set in round-robin mode: grants run in strictly descending index order with wrap.

## Test plan
All scenarios use N=8.

1. **Reset:** hold rst_n=0 with req=8'hFF for 3 cycles -> out_valid=0, out_idx=0, out_onehot=0. Release with rr_en=1 and out_ready=1 -> the first grant has out_idx=7 and out_onehot=8'h80.
2. **Fixed priority:** rr_en=0, out_ready=1, req=8'b0010_0100 held -> out_idx=5 on every cycle. Then req=8'h00 -> out_valid=0 and out_idx=0 one cycle later.
3. **Round-robin sweep:** rr_en=1, out_ready=1, req=8'hFF -> out_idx sequence is 7,6,5,4,3,2,1,0,7, one per cycle with no gaps.
4. **Sparse round-robin:** rr_en=1, out_ready=1, req=8'b1000_0001 -> out_idx alternates 7,0,7,0. Switch to rr_en=0 -> out_idx stays at 7.
5. **Back-pressure:** rr_en=0. With req=8'h08 and out_ready=0, out_idx=3 is granted. Then change req to 8'h80 for 4 cycles -> out_idx stays 3 and out_valid stays 1. Raise out_ready for one cycle -> out_idx=7 on the following cycle.
6. **Reset mid-hold:** rr_en=1 and a grant of out_idx=4 is held with out_ready=0. Assert rst_n=0 for 1 cycle -> out_valid=0. After release with req=8'hFF, the first out_idx is 7, showing ptr was restored to N-1.
